// File: rtl/winograd_acc.sv
// winograd_acc: LANES parallel 3-tap convolutions sharing one filter, computed in
// Winograd F(2,3) form (4 multiplies per lane) and accumulated across input channels.
// Pipeline: S1 input registers, S2 transform + multiply, S3 accumulate, S4 output hold.
module winograd_acc #(
   parameter int DATA_W = 8,
   parameter int WGT_W  = 4,
   parameter int LANES  = 4,
   parameter int ACC_W  = 24
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              signed_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic              in_last_i,
   input  logic [DATA_W-1:0] data_i [LANES][4],
   input  logic [WGT_W-1:0]  wgt_i  [3],
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [ACC_W-1:0]  out_o  [LANES][2],
   output logic              ovf_o
);

   // Internal math width: ACC_W >= DATA_W+WGT_W+4 makes ACC_W+2 wide enough for the
   // 2x-scaled products and their three-term sums without any loss.
   localparam int MW = ACC_W + 2;

   logic advance;

   logic              s1_valid, s1_last, s1_signed;
   logic [DATA_W-1:0] s1_data [LANES][4];
   logic [WGT_W-1:0]  s1_wgt  [3];

   logic signed [MW-1:0] filt [4];
   logic signed [MW-1:0] dtr  [LANES][4];
   logic signed [MW-1:0] prod [LANES][4];

   logic                 s2_valid, s2_last, s2_signed;
   logic signed [MW-1:0] s2_prod [LANES][4];

   logic [ACC_W-1:0] contrib [LANES][2];
   logic [ACC_W:0]   sum_ext [LANES][2];
   logic             add_ovf;

   logic             s3_valid, s3_last, acc_load;
   logic [ACC_W-1:0] acc [LANES][2];

   function automatic logic signed [MW-1:0] ext_data(input logic [DATA_W-1:0] v, input logic sgn);
      return {{(MW-DATA_W){sgn & v[DATA_W-1]}}, v};
   endfunction

   function automatic logic signed [MW-1:0] ext_wgt(input logic [WGT_W-1:0] v, input logic sgn);
      return {{(MW-WGT_W){sgn & v[WGT_W-1]}}, v};
   endfunction

   // The whole pipeline stalls only when a finished result is waiting and not taken.
   assign advance    = !(out_valid_o && !out_ready_i);
   assign in_ready_o = advance;

   // S1 control: capture beat valid/last/sign; bubbles enter as invalid slots.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid  <= 1'b0;
         s1_last   <= 1'b0;
         s1_signed <= 1'b0;
      end else if (advance) begin
         s1_valid  <= in_valid_i;
         s1_last   <= in_last_i;
         s1_signed <= signed_i;
      end
   end

   // S1 datapath: operand registers, no reset needed since valid bits qualify them.
   always_ff @(posedge clk_i) begin
      if (advance) begin
         s1_data <= data_i;
         s1_wgt  <= wgt_i;
      end
   end

   // Filter transform scaled by 2 so the usual halves of g0+-g1+g2 stay integral.
   always_comb begin
      filt[0] = ext_wgt(s1_wgt[0], s1_signed) <<< 1;
      filt[1] = ext_wgt(s1_wgt[0], s1_signed) + ext_wgt(s1_wgt[1], s1_signed)
              + ext_wgt(s1_wgt[2], s1_signed);
      filt[2] = ext_wgt(s1_wgt[0], s1_signed) - ext_wgt(s1_wgt[1], s1_signed)
              + ext_wgt(s1_wgt[2], s1_signed);
      filt[3] = ext_wgt(s1_wgt[2], s1_signed) <<< 1;
   end

   // Data transform and the four element-wise multiplies per lane.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         dtr[l][0] = ext_data(s1_data[l][0], s1_signed) - ext_data(s1_data[l][2], s1_signed);
         dtr[l][1] = ext_data(s1_data[l][1], s1_signed) + ext_data(s1_data[l][2], s1_signed);
         dtr[l][2] = ext_data(s1_data[l][2], s1_signed) - ext_data(s1_data[l][1], s1_signed);
         dtr[l][3] = ext_data(s1_data[l][1], s1_signed) - ext_data(s1_data[l][3], s1_signed);
         for (int k = 0; k < 4; k++) begin
            prod[l][k] = dtr[l][k] * filt[k];
         end
      end
   end

   // S2 control: product-stage valid/last/sign tracking.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s2_valid  <= 1'b0;
         s2_last   <= 1'b0;
         s2_signed <= 1'b0;
      end else if (advance) begin
         s2_valid  <= s1_valid;
         s2_last   <= s1_last;
         s2_signed <= s1_signed;
      end
   end

   // S2 datapath: product registers.
   always_ff @(posedge clk_i) begin
      if (advance) begin
         s2_prod <= prod;
      end
   end

   // Output transform with the exact divide-by-2, running sums and overflow detection.
   always_comb begin
      add_ovf = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         contrib[l][0] = ACC_W'((s2_prod[l][0] + s2_prod[l][1] + s2_prod[l][2]) >>> 1);
         contrib[l][1] = ACC_W'((s2_prod[l][1] - s2_prod[l][2] - s2_prod[l][3]) >>> 1);
         for (int e = 0; e < 2; e++) begin
            sum_ext[l][e] = {1'b0, acc[l][e]} + {1'b0, contrib[l][e]};
            if (s2_signed) begin
               if ((acc[l][e][ACC_W-1] == contrib[l][e][ACC_W-1]) &&
                   (sum_ext[l][e][ACC_W-1] != acc[l][e][ACC_W-1])) begin
                  add_ovf = 1'b1;
               end
            end else if (sum_ext[l][e][ACC_W]) begin
               add_ovf = 1'b1;
            end
         end
      end
   end

   // S3: load on the first beat of an accumulation, add afterwards; overflow is sticky.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s3_valid <= 1'b0;
         s3_last  <= 1'b0;
         acc_load <= 1'b1;
         ovf_o    <= 1'b0;
         for (int l = 0; l < LANES; l++) begin
            for (int e = 0; e < 2; e++) begin
               acc[l][e] <= '0;
            end
         end
      end else if (advance) begin
         s3_valid <= s2_valid;
         s3_last  <= s2_last;
         if (s2_valid) begin
            acc_load <= s2_last;
            if (!acc_load && add_ovf) begin
               ovf_o <= 1'b1;
            end
            for (int l = 0; l < LANES; l++) begin
               for (int e = 0; e < 2; e++) begin
                  acc[l][e] <= acc_load ? contrib[l][e] : sum_ext[l][e][ACC_W-1:0];
               end
            end
         end
      end
   end

   // S4: hold the finished sum until taken; a new one may replace it in the drain cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_o <= 1'b0;
         for (int l = 0; l < LANES; l++) begin
            for (int e = 0; e < 2; e++) begin
               out_o[l][e] <= '0;
            end
         end
      end else if (advance) begin
         out_valid_o <= s3_valid && s3_last;
         if (s3_valid && s3_last) begin
            out_o <= acc;
         end
      end
   end

endmodule

// File: tb/tb_winograd_acc.sv
// tb_winograd_acc: scoreboard bench for winograd_acc using a direct-convolution model.
module tb_winograd_acc;

   localparam int DATA_W = 8;
   localparam int WGT_W  = 4;
   localparam int LANES  = 4;
   localparam int ACC_W  = 24;

   typedef logic [LANES*2*ACC_W-1:0] exp_t;

   logic              clk_i;
   logic              rst_i;
   logic              signed_i;
   logic              in_valid_i;
   logic              in_ready_o;
   logic              in_last_i;
   logic [DATA_W-1:0] data_i [LANES][4];
   logic [WGT_W-1:0]  wgt_i  [3];
   logic              out_valid_o;
   logic              out_ready_i;
   logic [ACC_W-1:0]  out_o  [LANES][2];
   logic              ovf_o;

   logic [DATA_W-1:0] stim_data [LANES][4];
   logic [WGT_W-1:0]  stim_wgt  [3];

   exp_t   sb_q[$];
   longint model_acc [LANES][2];
   bit     model_fresh;
   bit     model_ovf;
   bit     ready_hold;
   bit     rand_ready;
   int     n_checks;
   int     n_errors;
   int     n_out;
   int     n_pushed;

   winograd_acc #(
      .DATA_W(DATA_W),
      .WGT_W (WGT_W),
      .LANES (LANES),
      .ACC_W (ACC_W)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .signed_i   (signed_i),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .in_last_i  (in_last_i),
      .data_i     (data_i),
      .wgt_i      (wgt_i),
      .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i),
      .out_o      (out_o),
      .ovf_o      (ovf_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, act, expv);
      end
   endtask

   function automatic longint sext(input logic [63:0] v, input int w, input bit sgn);
      longint r;
      r = longint'(v & ((64'd1 << w) - 64'd1));
      if (sgn && v[w-1]) r = r - (longint'(1) << w);
      return r;
   endfunction

   function automatic longint wrap(input longint x);
      longint m;
      m = longint'(1) << ACC_W;
      return ((x % m) + m) % m;
   endfunction

   // Reference: plain dot products, range-based overflow test, results queued on last beat.
   task automatic modelBeat(input bit sgn, input bit last);
      longint dv[4];
      longint gv[3];
      longint y, s, sv, half, m;
      exp_t   e;
      m    = longint'(1) << ACC_W;
      half = m / 2;
      for (int l = 0; l < LANES; l++) begin
         for (int k = 0; k < 4; k++) dv[k] = sext(64'(stim_data[l][k]), DATA_W, sgn);
         for (int k = 0; k < 3; k++) gv[k] = sext(64'(stim_wgt[k]), WGT_W, sgn);
         for (int o = 0; o < 2; o++) begin
            y = dv[o]*gv[0] + dv[o+1]*gv[1] + dv[o+2]*gv[2];
            if (model_fresh) begin
               model_acc[l][o] = wrap(y);
            end else begin
               if (sgn) begin
                  sv = (model_acc[l][o] >= half) ? model_acc[l][o] - m : model_acc[l][o];
                  s  = sv + y;
                  if (s < -half || s >= half) model_ovf = 1'b1;
               end else begin
                  s = model_acc[l][o] + y;
                  if (s >= m) model_ovf = 1'b1;
               end
               model_acc[l][o] = wrap(s);
            end
         end
      end
      model_fresh = last;
      if (last) begin
         e = '0;
         for (int l = 0; l < LANES; l++)
            for (int o = 0; o < 2; o++)
               e[(l*2+o)*ACC_W +: ACC_W] = ACC_W'(model_acc[l][o]);
         sb_q.push_back(e);
         n_pushed++;
      end
   endtask

   task automatic setTile(input int d0, input int d1, input int d2, input int d3,
                          input int g0, input int g1, input int g2);
      for (int l = 0; l < LANES; l++) begin
         stim_data[l][0] = DATA_W'(d0);
         stim_data[l][1] = DATA_W'(d1);
         stim_data[l][2] = DATA_W'(d2);
         stim_data[l][3] = DATA_W'(d3);
      end
      stim_wgt[0] = WGT_W'(g0);
      stim_wgt[1] = WGT_W'(g1);
      stim_wgt[2] = WGT_W'(g2);
   endtask

   task automatic setRandom();
      for (int l = 0; l < LANES; l++)
         for (int k = 0; k < 4; k++) stim_data[l][k] = DATA_W'($urandom);
      for (int k = 0; k < 3; k++) stim_wgt[k] = WGT_W'($urandom);
   endtask

   // Offer one beat after some bubbles; called and returns 1ns after a rising edge.
   task automatic applyStimulus(input bit sgn, input bit last, input int bubbles);
      bit accepted;
      int waited;
      in_valid_i = 1'b0;
      repeat (bubbles) begin
         @(posedge clk_i);
         #1;
      end
      signed_i   = sgn;
      in_last_i  = last;
      data_i     = stim_data;
      wgt_i      = stim_wgt;
      in_valid_i = 1'b1;
      accepted   = 1'b0;
      waited     = 0;
      while (!accepted && waited < 200) begin
         @(negedge clk_i);
         accepted = in_ready_o;
         @(posedge clk_i);
         #1;
         waited++;
      end
      in_valid_i = 1'b0;
      if (accepted) modelBeat(sgn, last);
      else checkOutput("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 500) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      if (sb_q.size() != 0) checkOutput("drain_timeout", 64'(sb_q.size()), 64'd0);
      repeat (3) begin
         @(posedge clk_i);
         #1;
      end
      checkOutput("idle_valid", 64'(out_valid_o), 64'd0);
   endtask

   // Consumer ready: fixed level or random throttling.
   initial begin
      out_ready_i = 1'b1;
      forever begin
         @(posedge clk_i);
         #1;
         out_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : ready_hold;
      end
   end

   // Result monitor: every transferred result is compared against the scoreboard head.
   always @(negedge clk_i) begin
      exp_t e;
      if (!rst_i && out_valid_o && out_ready_i) begin
         n_out++;
         if (sb_q.size() == 0) begin
            checkOutput("unexpected_result", 64'd1, 64'd0);
         end else begin
            e = sb_q.pop_front();
            for (int l = 0; l < LANES; l++)
               for (int o = 0; o < 2; o++)
                  checkOutput($sformatf("lane%0d_y%0d", l, o), 64'(out_o[l][o]),
                              64'(e[(l*2+o)*ACC_W +: ACC_W]));
         end
      end
   end

   // Hard stop if the sequence below ever stalls.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed and random sequence.
   initial begin
      int len;
      bit sgn;
      n_checks = 0; n_errors = 0; n_out = 0; n_pushed = 0;
      model_fresh = 1'b1; model_ovf = 1'b0;
      ready_hold = 1'b1; rand_ready = 1'b0;
      rst_i = 1'b1; signed_i = 1'b0; in_valid_i = 1'b0; in_last_i = 1'b0;
      setTile(0, 0, 0, 0, 0, 0, 0);
      data_i = stim_data;
      wgt_i  = stim_wgt;
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      checkOutput("rst_out_valid", 64'(out_valid_o), 64'd0);
      checkOutput("rst_in_ready", 64'(in_ready_o), 64'd1);
      checkOutput("rst_ovf", 64'(ovf_o), 64'd0);
      checkOutput("rst_out0", 64'(out_o[0][0]), 64'd0);
      checkOutput("rst_out_last", 64'(out_o[LANES-1][1]), 64'd0);
      @(posedge clk_i);
      #1;

      $display("[TB] unsigned single beat with latency");
      setTile(1, 2, 3, 4, 1, 1, 1);
      applyStimulus(1'b0, 1'b1, 0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i);
         checkOutput($sformatf("latency_c%0d", c), 64'(out_valid_o), 64'(c == 3));
      end
      @(posedge clk_i);
      #1;
      waitIdle();

      $display("[TB] signed extremes");
      setTile(-128, 127, -1, 0, -8, 7, -1);
      applyStimulus(1'b1, 1'b1, 0);
      waitIdle();

      $display("[TB] three-beat accumulation");
      setTile(1, 1, 1, 1, 1, 1, 1);
      applyStimulus(1'b0, 1'b0, 0);
      applyStimulus(1'b0, 1'b0, 0);
      applyStimulus(1'b0, 1'b1, 0);
      waitIdle();

      $display("[TB] sign mode change mid accumulation with bubbles");
      setTile(-128, 127, -1, 0, -8, 7, -1);
      applyStimulus(1'b1, 1'b0, 1);
      setTile(1, 2, 3, 4, 1, 1, 1);
      applyStimulus(1'b0, 1'b1, 2);
      waitIdle();

      $display("[TB] random accumulations with throttled consumer");
      rand_ready = 1'b1;
      for (int a = 0; a < 30; a++) begin
         len = $urandom_range(1, 4);
         sgn = 1'($urandom_range(0, 1));
         for (int b = 0; b < len; b++) begin
            setRandom();
            applyStimulus(sgn, b == len - 1, $urandom_range(0, 2));
         end
      end
      rand_ready = 1'b0;
      waitIdle();
      checkOutput("ovf_model", 64'(ovf_o), 64'(model_ovf));

      $display("[TB] backpressure with pending result");
      ready_hold = 1'b0;
      repeat (2) begin
         @(posedge clk_i);
         #1;
      end
      for (int b = 0; b < 3; b++) begin
         setRandom();
         applyStimulus(1'b0, 1'b1, 0);
      end
      fork
         begin
            setRandom();
            applyStimulus(1'b1, 1'b1, 0);
            setRandom();
            applyStimulus(1'b0, 1'b1, 0);
         end
         begin
            int w;
            w = 0;
            @(negedge clk_i);
            while (!out_valid_o && w < 20) begin
               @(negedge clk_i);
               w++;
            end
            checkOutput("stall_wait", 64'(out_valid_o), 64'd1);
            for (int c = 0; c < 5; c++) begin
               checkOutput("stall_in_ready", 64'(in_ready_o), 64'd0);
               if (sb_q.size() != 0) begin
                  for (int l = 0; l < LANES; l++)
                     checkOutput("stall_hold", 64'(out_o[l][0]), 64'(sb_q[0][(l*2)*ACC_W +: ACC_W]));
               end else begin
                  checkOutput("stall_queue", 64'(sb_q.size()), 64'd1);
               end
               @(negedge clk_i);
            end
            @(posedge clk_i);
            #1;
            ready_hold = 1'b1;
         end
      join
      waitIdle();

      $display("[TB] unsigned wraparound and sticky overflow");
      setTile(255, 255, 255, 255, 15, 15, 15);
      for (int i = 0; i < 1500; i++) applyStimulus(1'b0, i == 1499, 0);
      waitIdle();
      checkOutput("ovf_set", 64'(ovf_o), 64'd1);
      setTile(1, 2, 3, 4, 1, 1, 1);
      applyStimulus(1'b0, 1'b1, 0);
      waitIdle();
      checkOutput("ovf_sticky", 64'(ovf_o), 64'd1);

      $display("[TB] reset in the middle of an accumulation");
      setTile(5, 6, 7, 8, 2, 3, 1);
      applyStimulus(1'b0, 1'b0, 0);
      applyStimulus(1'b0, 1'b0, 0);
      rst_i = 1'b1;
      model_fresh = 1'b1;
      model_ovf   = 1'b0;
      repeat (2) begin
         @(posedge clk_i);
         #1;
      end
      rst_i = 1'b0;
      @(negedge clk_i);
      checkOutput("midrst_out_valid", 64'(out_valid_o), 64'd0);
      checkOutput("midrst_in_ready", 64'(in_ready_o), 64'd1);
      checkOutput("midrst_ovf", 64'(ovf_o), 64'd0);
      checkOutput("midrst_out0", 64'(out_o[0][0]), 64'd0);
      @(posedge clk_i);
      #1;
      setTile(1, 2, 3, 4, 1, 1, 1);
      applyStimulus(1'b0, 1'b1, 0);
      waitIdle();

      checkOutput("result_count", 64'(n_out), 64'(n_pushed));
      checkOutput("queue_empty", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
